// File: rtl/pk_serializer_pkg.sv
// Shared types and constants for the peak/config record serializer.
// Holds the beat-count derivation, FSM encoding and record field beat indices.
package pk_serializer_pkg;

  localparam int IN_WIDTH_DEF  = 512;
  localparam int OUT_WIDTH_DEF = 64;

  function automatic int beats_of(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  localparam int BEATS_DEF = IN_WIDTH_DEF / OUT_WIDTH_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Beat index of each 64-bit record field, LSW first.
  // Beats 0-3 are the config block, 4-7 the peak block.
  localparam int BEAT_COUNTER_ID = 0;
  localparam int BEAT_CHIRP_CTRL = 1;
  localparam int BEAT_CFG_WORD2  = 2;
  localparam int BEAT_CFG_WORD3  = 3;
  localparam int BEAT_PEAK_0     = 4;
  localparam int BEAT_PEAK_1     = 5;
  localparam int BEAT_PEAK_2     = 6;
  localparam int BEAT_PEAK_NUM   = 7;

endpackage

// File: rtl/pk_record_fifo.sv
// Synchronous record FIFO, WIDTH x DEPTH, registered level and flags.
// Ports: aclk/aresetn, push/wr_data, pop/rd_data, full, empty, level.
module pk_record_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage has no reset so it maps onto distributed/block RAM.
  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pk_record_serializer.sv
// Buffers wide peak/config records and emits each as one packet of OUT_WIDTH
// beats, LSW first, tlast on the final beat. Ports: s_axis_* record input,
// m_axis_* beat output, fifo_level (records queued), records_sent counter.
module pk_record_serializer
  import pk_serializer_pkg::*;
#(
  parameter int IN_WIDTH   = 512,
  parameter int OUT_WIDTH  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [IN_WIDTH-1:0]           s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [OUT_WIDTH-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [OUT_WIDTH/8-1:0]        m_axis_tkeep,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   records_sent
);

  localparam int BEATS = beats_of(IN_WIDTH, OUT_WIDTH);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  ser_state_t            state_q;
  ser_state_t            state_n;
  logic [IN_WIDTH-1:0]   sreg_q;
  logic [IN_WIDTH-1:0]   sreg_n;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_n;
  logic                  pop;
  logic                  sent_inc;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [IN_WIDTH-1:0]   fifo_rd;
  logic                  unused_tlast;

  // Every input beat is a whole record.
  assign unused_tlast = s_axis_tlast;

  // Ready comes from the registered level only; no pass-through when full.
  assign s_axis_tready = !fifo_full;
  assign push          = s_axis_tvalid && s_axis_tready;

  pk_record_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .wr_data (s_axis_tdata),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tlast  = m_axis_tvalid && (cnt_q == LAST_BEAT);
  assign m_axis_tdata  = sreg_q[OUT_WIDTH-1:0];
  assign m_axis_tkeep  = '1;

  always_comb begin
    state_n  = state_q;
    sreg_n   = sreg_q;
    cnt_n    = cnt_q;
    pop      = 1'b0;
    sent_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sreg_n  = fifo_rd;
          cnt_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (cnt_q != LAST_BEAT) begin
            sreg_n = sreg_q >> OUT_WIDTH;
            cnt_n  = cnt_q + 1'b1;
          end else begin
            sent_inc = 1'b1;
            // Chain straight into the next record: no idle cycle.
            if (!fifo_empty) begin
              pop    = 1'b1;
              sreg_n = fifo_rd;
              cnt_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      sreg_q  <= sreg_n;
      cnt_q   <= cnt_n;
    end
  end

  // Written only on a completed packet so the count holds between packets.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      records_sent <= '0;
    end else if (sent_inc) begin
      records_sent <= records_sent + 32'd1;
    end
  end

endmodule
